// File: rtl/stream_pkg.sv
// Shared definitions for the gen_seq / seq_chk stream protocol:
// flag bit positions on both directions and the checker's framing states.
package stream_pkg;

  // Downstream flags uc_mflags = {A,F,L,V}
  localparam int MF_V = 0;
  localparam int MF_L = 1;
  localparam int MF_F = 2;
  localparam int MF_A = 3;

  // Upstream flags cu_sflags = {ERR,BSY}
  localparam int SF_BSY = 0;
  localparam int SF_ERR = 1;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_e;

  typedef enum logic {
    BP_OFF = 1'b0,
    BP_ON  = 1'b1
  } bp_phase_e;

endpackage : stream_pkg

// File: rtl/seq_chk_bp_gen.sv
// Back-pressure pattern generator: alternates an OFF phase (BSY=0) and an ON
// phase (BSY=1) whose lengths are latched when each phase begins.
module bp_gen
  import stream_pkg::*;
#(
  parameter int BP_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BP_W-1:0] off_len,
  input  logic [BP_W-1:0] on_len,
  output logic            bsy
);

  bp_phase_e       phase_q, phase_d;
  logic [BP_W-1:0] cnt_q, cnt_d;
  logic [BP_W-1:0] len_q, len_d;
  logic            len_vld_q, len_vld_d;
  logic [BP_W-1:0] cur_len;
  logic            phase_end;

  // The first OFF phase after reset has no latched length yet, so it follows
  // the live off_len until the first phase boundary.
  assign cur_len   = len_vld_q ? len_q : off_len;
  assign phase_end = ((BP_W+1)'(cnt_q) + (BP_W+1)'(1)) >= (BP_W+1)'(cur_len);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q + BP_W'(1);
    len_d     = len_q;
    len_vld_d = len_vld_q;
    if (phase_end) begin
      cnt_d     = '0;
      len_vld_d = 1'b1;
      if (on_len == '0) begin
        phase_d = BP_OFF;
        len_d   = off_len;
      end else if (phase_q == BP_OFF || off_len == '0) begin
        phase_d = BP_ON;
        len_d   = on_len;
      end else begin
        phase_d = BP_OFF;
        len_d   = off_len;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= BP_OFF;
      cnt_q     <= '0;
      len_q     <= '0;
      len_vld_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      len_vld_q <= len_vld_d;
    end
  end

  assign bsy = (phase_q == BP_ON);

endmodule : bp_gen

// File: rtl/seq_chk.sv
// Stream sink/checker: accepts words under programmable back-pressure, checks
// data against an ini/max/inc sequence and F/L/A framing, counts and captures.
module seq_chk
  import stream_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 16,
  parameter int BP_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     uc_d0,
  input  logic [3:0]       uc_mflags,
  output logic [1:0]       cu_sflags,
  input  logic             clr,
  input  logic [W-1:0]     cnt_ini,
  input  logic [W-1:0]     cnt_max,
  input  logic [W-1:0]     cnt_inc,
  input  logic [BP_W-1:0]  bp_off_len,
  input  logic [BP_W-1:0]  bp_on_len,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [W-1:0]     err_exp,
  output logic [W-1:0]     err_got,
  output logic             in_frame
);

  logic         bsy;
  logic         acc;
  logic         first, last, abort;

  frame_state_e state_q, state_d;
  logic         frm_err;
  logic         frame_done;

  logic [W-1:0] exp_q;
  logic         exp_vld_q;
  logic [W-1:0] exp_cur;
  logic [W:0]   exp_sum;
  logic [W-1:0] exp_nxt;
  logic         data_err;
  logic         word_err;

  logic         sticky_q;
  logic         cap_done_q;

  bp_gen #(.BP_W(BP_W)) u_bp_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .off_len (bp_off_len),
    .on_len  (bp_on_len),
    .bsy     (bsy)
  );

  assign first = uc_mflags[MF_F];
  assign last  = uc_mflags[MF_L];
  assign abort = uc_mflags[MF_A];
  assign acc   = uc_mflags[MF_V] & ~bsy;

  // NOTE: the expected-value register restarts at cnt_ini, a live input; a
  // flop cannot reset asynchronously to a non-constant, so a valid flag resets
  // instead and cnt_ini is selected until the first accepted word.
  assign exp_cur  = exp_vld_q ? exp_q : cnt_ini;
  assign exp_sum  = {1'b0, exp_cur} + {1'b0, cnt_inc};
  assign exp_nxt  = (exp_sum > {1'b0, cnt_max}) ? cnt_ini : exp_sum[W-1:0];
  assign data_err = (uc_d0 != exp_cur);

  // A missing F in IDLE is an implicit start and an F inside a frame is a
  // restart; both report a framing error but follow the normal transitions.
  always_comb begin
    state_d    = state_q;
    frm_err    = 1'b0;
    frame_done = 1'b0;
    if (acc) begin
      frm_err = (state_q == IDLE) ? ~first : first;
      if (abort) begin
        state_d = IDLE;
      end else if (last) begin
        state_d    = IDLE;
        frame_done = 1'b1;
      end else begin
        state_d = IN_FRAME;
      end
    end
  end

  assign word_err = data_err | frm_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      exp_q      <= '0;
      exp_vld_q  <= 1'b0;
      word_cnt   <= '0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
      err_exp    <= '0;
      err_got    <= '0;
      sticky_q   <= 1'b0;
      cap_done_q <= 1'b0;
    end else if (clr) begin
      state_q    <= IDLE;
      exp_q      <= '0;
      exp_vld_q  <= 1'b0;
      word_cnt   <= '0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
      err_exp    <= '0;
      err_got    <= '0;
      sticky_q   <= 1'b0;
      cap_done_q <= 1'b0;
    end else if (acc) begin
      state_q   <= state_d;
      exp_q     <= exp_nxt;
      exp_vld_q <= 1'b1;
      word_cnt  <= word_cnt + CNT_W'(1);
      if (frame_done) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      // One error per word even when data and framing both fail.
      if (word_err && !(&err_cnt)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      if (word_err) begin
        sticky_q <= 1'b1;
      end
      if (data_err && !cap_done_q) begin
        err_exp    <= exp_cur;
        err_got    <= uc_d0;
        cap_done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    cu_sflags         = '0;
    cu_sflags[SF_BSY] = bsy;
    cu_sflags[SF_ERR] = sticky_q;
  end

  assign in_frame = (state_q == IN_FRAME);

  a_sticky_holds : assert property (
    @(posedge clk) disable iff (!rst_n) (sticky_q && !clr) |=> sticky_q);

  a_err_cnt_monotonic : assert property (
    @(posedge clk) disable iff (!rst_n) !clr |=> (err_cnt >= $past(err_cnt)));

endmodule : seq_chk

// File: tb/tb_seq_chk.sv
// Self-checking bench for seq_chk: a reactive stream driver feeds words,
// a reference model pushes expected counters into a scoreboard queue.
module tb_seq_chk;

  localparam int W     = 16;
  localparam int CNT_W = 16;
  localparam int BP_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     uc_d0 = '0;
  logic [3:0]       uc_mflags = '0;
  logic [1:0]       cu_sflags;
  logic             clr = 1'b0;
  logic [W-1:0]     cnt_ini = '0;
  logic [W-1:0]     cnt_max = '0;
  logic [W-1:0]     cnt_inc = '0;
  logic [BP_W-1:0]  bp_off_len = '0;
  logic [BP_W-1:0]  bp_on_len = '0;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [W-1:0]     err_exp;
  logic [W-1:0]     err_got;
  logic             in_frame;

  always #5 clk = ~clk;

  seq_chk #(.W(W), .CNT_W(CNT_W), .BP_W(BP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uc_d0      (uc_d0),
    .uc_mflags  (uc_mflags),
    .cu_sflags  (cu_sflags),
    .clr        (clr),
    .cnt_ini    (cnt_ini),
    .cnt_max    (cnt_max),
    .cnt_inc    (cnt_inc),
    .bp_off_len (bp_off_len),
    .bp_on_len  (bp_on_len),
    .word_cnt   (word_cnt),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt),
    .err_exp    (err_exp),
    .err_got    (err_got),
    .in_frame   (in_frame)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [CNT_W-1:0] words;
    logic [CNT_W-1:0] frames;
    logic [CNT_W-1:0] errs;
    logic             in_frame;
    logic             err;
  } sb_t;

  sb_t              sb_q[$];
  logic [W-1:0]     m_exp;
  logic             m_in_frame;
  logic [CNT_W-1:0] m_words, m_frames, m_errs;
  logic             m_sticky;
  logic [W-1:0]     g;

  function automatic logic [W-1:0] seq_next(input logic [W-1:0] v);
    logic [W:0] s;
    s = {1'b0, v} + {1'b0, cnt_inc};
    return (s > {1'b0, cnt_max}) ? cnt_ini : s[W-1:0];
  endfunction

  task automatic model_clear();
    m_exp      = cnt_ini;
    m_in_frame = 1'b0;
    m_words    = '0;
    m_frames   = '0;
    m_errs     = '0;
    m_sticky   = 1'b0;
  endtask

  task automatic model_accept(input logic [W-1:0] d, input bit f, input bit l, input bit a);
    bit derr, ferr;
    derr  = (d != m_exp);
    m_exp = seq_next(m_exp);
    ferr  = m_in_frame ? f : !f;
    if (a) m_in_frame = 1'b0;
    else if (l) begin
      m_in_frame = 1'b0;
      m_frames++;
    end else m_in_frame = 1'b1;
    m_words++;
    if ((derr || ferr) && m_errs != '1) m_errs++;
    if (derr || ferr) m_sticky = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic send_word(input logic [W-1:0] d, input bit f, input bit l, input bit a);
    int budget;
    uc_d0     = d;
    uc_mflags = {a, f, l, 1'b1};
    budget    = 0;
    while (cu_sflags[0] === 1'b1) begin
      if (budget == 64) begin
        check("bsy_timeout", 32'(cu_sflags[0]), 32'd0);
        uc_mflags = '0;
        return;
      end
      @(negedge clk);
      budget++;
    end
    @(posedge clk);
    if (clr) model_clear();
    else model_accept(d, f, l, a);
    sb_q.push_back('{m_words, m_frames, m_errs, m_in_frame, m_sticky});
    @(negedge clk);
    uc_mflags = '0;
  endtask

  task automatic tw(input bit f, input bit l, input bit a);
    send_word(g, f, l, a);
    g = seq_next(g);
  endtask

  task automatic send_seq(input int n, input int flen, input int bad_idx);
    for (int i = 0; i < n; i++) begin
      send_word((i == bad_idx) ? W'(16'h0055) : g, (i % flen) == 0, (i % flen) == flen - 1, 1'b0);
      g = seq_next(g);
    end
  endtask

  task automatic do_reset(input logic [W-1:0] ini, input logic [W-1:0] mx, input logic [W-1:0] inc,
                          input logic [BP_W-1:0] off, input logic [BP_W-1:0] on);
    @(negedge clk);
    rst_n      = 1'b0;
    uc_mflags  = '0;
    clr        = 1'b0;
    cnt_ini    = ini;
    cnt_max    = mx;
    cnt_inc    = inc;
    bp_off_len = off;
    bp_on_len  = on;
    model_clear();
    g = ini;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: results of an accept are visible at the following negedge.
  always @(negedge clk) begin
    sb_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("sb_word_cnt",  32'(word_cnt),     32'(e.words));
      check("sb_frame_cnt", 32'(frame_cnt),    32'(e.frames));
      check("sb_err_cnt",   32'(err_cnt),      32'(e.errs));
      check("sb_in_frame",  32'(in_frame),     32'(e.in_frame));
      check("sb_sflag_err", 32'(cu_sflags[1]), 32'(e.err));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: plain stream, no back-pressure
    do_reset(16'd1, 16'd15, 16'd1, 8'd0, 8'd0);
    check("rst_word_cnt",  32'(word_cnt),  32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    check("rst_err_exp",   32'(err_exp),   32'd0);
    check("rst_sflags",    32'(cu_sflags), 32'd0);
    check("rst_in_frame",  32'(in_frame),  32'd0);
    send_seq(30, 15, -1);
    check("t1_word_cnt",  32'(word_cnt),  32'd30);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd2);
    check("t1_err_cnt",   32'(err_cnt),   32'd0);
    check("t1_sflags",    32'(cu_sflags), 32'd0);

    // 2: back-pressure 10 off / 2 on
    do_reset(16'd1, 16'd15, 16'd1, 8'd10, 8'd2);
    for (int n = 0; n < 24; n++) begin
      check("t2_bsy_pattern", 32'(cu_sflags[0]), 32'((n % 12) >= 10));
      @(negedge clk);
    end
    send_seq(30, 15, -1);
    check("t2_word_cnt",  32'(word_cnt),  32'd30);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd2);
    check("t2_err_cnt",   32'(err_cnt),   32'd0);

    // 3: corrupted 5th word
    do_reset(16'd1, 16'd15, 16'd1, 8'd0, 8'd0);
    send_seq(8, 15, 4);
    check("t3_err_cnt", 32'(err_cnt),      32'd1);
    check("t3_err_exp", 32'(err_exp),      32'h5);
    check("t3_err_got", 32'(err_got),      32'h55);
    check("t3_sticky",  32'(cu_sflags[1]), 32'd1);

    // 4: wrapping step and constant stream
    do_reset(16'd3, 16'd10, 16'd4, 8'd0, 8'd0);
    send_seq(6, 6, -1);
    check("t4_inc4_err_cnt",  32'(err_cnt),   32'd0);
    check("t4_inc4_frame",    32'(frame_cnt), 32'd1);
    do_reset(16'd3, 16'd10, 16'd0, 8'd3, 8'd1);
    send_seq(5, 5, -1);
    check("t4_inc0_err_cnt",  32'(err_cnt),   32'd0);
    check("t4_inc0_word_cnt", 32'(word_cnt),  32'd5);

    // 5: framing errors and abort
    do_reset(16'd1, 16'd15, 16'd1, 8'd0, 8'd0);
    tw(1'b1, 1'b0, 1'b0);
    tw(1'b1, 1'b0, 1'b0);
    tw(1'b0, 1'b1, 1'b0);
    tw(1'b1, 1'b0, 1'b0);
    tw(1'b0, 1'b0, 1'b0);
    tw(1'b0, 1'b1, 1'b1);
    tw(1'b0, 1'b0, 1'b0);
    check("t5_err_cnt",   32'(err_cnt),   32'd2);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t5_word_cnt",  32'(word_cnt),  32'd7);
    check("t5_in_frame",  32'(in_frame),  32'd1);

    // 6: clr coincident with accept, then async reset mid-frame
    do_reset(16'd1, 16'd15, 16'd1, 8'd0, 8'd0);
    tw(1'b1, 1'b0, 1'b0);
    tw(1'b0, 1'b0, 1'b0);
    send_word(16'h0099, 1'b0, 1'b0, 1'b0);
    check("t6_pre_clr_err", 32'(err_cnt), 32'd1);
    clr = 1'b1;
    send_word(16'h0004, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    g   = cnt_ini;
    check("t6_clr_word_cnt", 32'(word_cnt),  32'd0);
    check("t6_clr_sflags",   32'(cu_sflags), 32'd0);
    check("t6_clr_err_got",  32'(err_got),   32'd0);
    tw(1'b1, 1'b0, 1'b0);
    send_word(16'h00aa, 1'b0, 1'b0, 1'b0);
    check("t6_err_exp", 32'(err_exp), 32'h2);
    check("t6_err_got", 32'(err_got), 32'haa);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_word_cnt",  32'(word_cnt),  32'd0);
    check("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t6_rst_err_cnt",   32'(err_cnt),   32'd0);
    check("t6_rst_err_exp",   32'(err_exp),   32'd0);
    check("t6_rst_err_got",   32'(err_got),   32'd0);
    check("t6_rst_in_frame",  32'(in_frame),  32'd0);
    check("t6_rst_sflags",    32'(cu_sflags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_chk
